// File: rtl/auc_loader.sv
// Packs host words into wide operands and replays them to the decoder on a launch command.
// Optional saturating error counter enabled by defining AUC_LOADER_ERRCNT_EN.
module auc_loader #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HWIDTH = 32,
    parameter int unsigned DEPTH  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wen,
    input  logic [HWIDTH-1:0] host_wdat,
    input  logic              host_cmd,
    input  logic [2:0]        host_mode,
    output logic              host_busy,
    output logic              host_err,
    output logic [WIDTH-1:0]  auc_dat,
    output logic              auc_start,
    output logic [2:0]        auc_mode,
    output logic [7:0]        err_cnt
);

    localparam int unsigned WPO = WIDTH / HWIDTH;
    localparam int unsigned WCW = (WPO > 1) ? $clog2(WPO) : 1;
    localparam int unsigned PW  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] opnd_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, idx_q, last_q;
    logic [WCW-1:0]   wcnt_q;
    logic             gap_q, start_q, busy_q, err_q;
    logic [WIDTH-1:0] dat_q;
    logic [2:0]       mode_q;

    logic [2:0] req_n, req_m1;
    logic       mode_ok, idle, full, cmd_ok, launch, drop_all, wr_en, err_d;

    always_comb begin
        req_n   = 3'd0;
        mode_ok = 1'b1;
        case (host_mode)
            3'd3:       req_n = 3'd2;
            3'd4:       req_n = 3'd5;
            3'd5:       req_n = 3'd4;
            3'd6, 3'd7: mode_ok = 1'b0;
            default:    req_n = 3'd0;
        endcase
        req_m1   = (req_n == 3'd0) ? 3'd0 : req_n - 3'd1;
        idle     = (state_q == StIdle);
        full     = (wr_ptr_q == PW'(DEPTH));
        cmd_ok   = mode_ok && (32'(wr_ptr_q) == 32'(req_n)) && (wcnt_q == '0);
        launch   = idle && host_cmd && !host_wen && cmd_ok;
        // Invalid launch and simultaneous write+launch both discard the buffer.
        drop_all = idle && host_cmd && !launch;
        wr_en    = idle && host_wen && !host_cmd && !full;
        err_d    = (host_wen && !idle) || drop_all || (idle && host_wen && !host_cmd && full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            wcnt_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            gap_q    <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            mode_q   <= 3'd0;
            for (int i = 0; i < int'(DEPTH); i++) opnd_q[i] <= '0;
        end else begin
            err_q <= err_d;
            if (wr_en) begin
                opnd_q[wr_ptr_q][wcnt_q*HWIDTH +: HWIDTH] <= host_wdat;
                if (wcnt_q == WCW'(WPO - 1)) begin
                    wcnt_q   <= '0;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
            if (drop_all) begin
                wr_ptr_q <= '0;
                wcnt_q   <= '0;
                for (int i = 0; i < int'(DEPTH); i++) opnd_q[i] <= '0;
            end
            case (state_q)
                StIdle: begin
                    if (launch) begin
                        state_q <= StSend;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        mode_q  <= host_mode;
                        idx_q   <= '0;
                        last_q  <= PW'(req_m1);
                        dat_q   <= (req_n == 3'd0) ? '0 : opnd_q[0];
                    end
                end
                StSend: begin
                    if (idx_q == last_q) begin
                        state_q <= StGap;
                        start_q <= 1'b0;
                        dat_q   <= '0;
                        gap_q   <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        dat_q <= opnd_q[idx_q + 1'b1];
                    end
                end
                StGap: begin
                    if (gap_q) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        mode_q   <= 3'd0;
                        wr_ptr_q <= '0;
                        wcnt_q   <= '0;
                        for (int i = 0; i < int'(DEPTH); i++) opnd_q[i] <= '0;
                    end else begin
                        gap_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef AUC_LOADER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_d && (err_cnt_q != 8'hff)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign host_busy = busy_q;
    assign host_err  = err_q;
    assign auc_dat   = dat_q;
    assign auc_start = start_q;
    assign auc_mode  = mode_q;

endmodule

// File: tb/tb_auc_loader.sv
// Scoreboard bench for auc_loader: a queue/array model predicts frames, errors and busy windows.
module tb_auc_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         host_wen = 1'b0;
    logic [31:0]  host_wdat = '0;
    logic         host_cmd = 1'b0;
    logic [2:0]   host_mode = '0;
    logic         host_busy, host_err, auc_start;
    logic [255:0] auc_dat;
    logic [2:0]   auc_mode;
    logic [7:0]   err_cnt;

    always #5 clk = ~clk;

    auc_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_wen  (host_wen),
        .host_wdat (host_wdat),
        .host_cmd  (host_cmd),
        .host_mode (host_mode),
        .host_busy (host_busy),
        .host_err  (host_err),
        .auc_dat   (auc_dat),
        .auc_start (auc_start),
        .auc_mode  (auc_mode),
        .err_cnt   (err_cnt)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int unsigned c; logic [255:0] d; logic [2:0] m;} st_t;
    typedef struct {int unsigned c; logic [7:0] n;} et_t;

    st_t          sq[$];
    et_t          eq[$];
    st_t          ms;
    et_t          me;
    int unsigned  busy_lo = 1, busy_hi = 0;
    logic [255:0] ops[$];
    logic [255:0] part = '0;
    int           pcnt = 0;
    int           errc = 0;
    bit           mon_en = 1'b0;
    int           checks = 0, errors = 0;

    function automatic int req_ops(logic [2:0] m);
        case (m)
            3'd3:    return 2;
            3'd4:    return 5;
            3'd5:    return 4;
            3'd6:    return -1;
            3'd7:    return -1;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_err(int unsigned c);
        et_t e;
`ifdef AUC_LOADER_ERRCNT_EN
        errc = (errc < 255) ? errc + 1 : 255;
`endif
        e.c = c;
        e.n = 8'(errc);
        eq.push_back(e);
    endtask

    task automatic clear_model();
        ops.delete();
        pcnt = 0;
        part = '0;
    endtask

    // One host cycle: drive at negedge, predict what the next rising edge produces.
    task automatic step(bit wen, logic [31:0] d, bit cmd, logic [2:0] m);
        int unsigned k;
        int          n, len;
        st_t         e;
        @(negedge clk);
        host_wen  = wen;
        host_wdat = d;
        host_cmd  = cmd;
        host_mode = m;
        k = cyc;
        if (k >= busy_lo && k <= busy_hi) begin
            if (wen) push_err(k + 1);
        end else if (wen && cmd) begin
            push_err(k + 1);
            clear_model();
        end else if (cmd) begin
            n = req_ops(m);
            if (n >= 0 && ops.size() == n && pcnt == 0) begin
                len = (n == 0) ? 1 : n;
                for (int i = 0; i < len; i++) begin
                    e.c = k + 1 + i;
                    e.d = (n == 0) ? '0 : ops[i];
                    e.m = m;
                    sq.push_back(e);
                end
                busy_lo = k + 1;
                busy_hi = k + len + 2;
            end else begin
                push_err(k + 1);
            end
            clear_model();
        end else if (wen) begin
            if (ops.size() == 5) begin
                push_err(k + 1);
            end else begin
                part[32*pcnt +: 32] = d;
                pcnt++;
                if (pcnt == 8) begin
                    ops.push_back(part);
                    part = '0;
                    pcnt = 0;
                end
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 3'd0);
    endtask

    task automatic load_rand(int nw);
        for (int i = 0; i < nw; i++) step(1'b1, $urandom, 1'b0, 3'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            while (eq.size() > 0 && eq[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL err_missing: got no pulse want pulse at cyc %0d", eq[0].c);
                void'(eq.pop_front());
            end
            while (sq.size() > 0 && sq[0].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL start_missing: got no frame want frame at cyc %0d", sq[0].c);
                void'(sq.pop_front());
            end
            if (host_err) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected at cyc %0d: got 1 want 0", cyc);
                end else begin
                    me = eq.pop_front();
                    chk("err_cycle", 256'(cyc), 256'(me.c));
                    chk("err_cnt", 256'(err_cnt), 256'(me.n));
                end
            end
            if (auc_start) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected at cyc %0d: got 1 want 0", cyc);
                end else begin
                    ms = sq.pop_front();
                    chk("start_cycle", 256'(cyc), 256'(ms.c));
                    chk("auc_dat", auc_dat, ms.d);
                    chk("auc_mode", 256'(auc_mode), 256'(ms.m));
                end
            end else begin
                chk("dat_idle_zero", auc_dat, '0);
            end
            chk("host_busy", 256'(host_busy), 256'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    task automatic chk_all_zero(string nm);
        chk({nm, "_start"}, 256'(auc_start), '0);
        chk({nm, "_dat"}, auc_dat, '0);
        chk({nm, "_mode"}, 256'(auc_mode), '0);
        chk({nm, "_busy"}, 256'(host_busy), '0);
        chk({nm, "_err"}, 256'(host_err), '0);
        chk({nm, "_errcnt"}, 256'(err_cnt), '0);
    endtask

    initial begin
        int m, n, nops, nw;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Five-operand launch with sequential words.
        for (int i = 1; i <= 40; i++) step(1'b1, 32'(i), 1'b0, 3'd0);
        step(1'b0, 32'd0, 1'b1, 3'd4);
        idle(8);

        // Zero-operand launch.
        step(1'b0, 32'd0, 1'b1, 3'd0);
        idle(4);

        // Operand-count mismatch, then prove the buffer was emptied.
        load_rand(24);
        step(1'b0, 32'd0, 1'b1, 3'd3);
        idle(1);
        step(1'b0, 32'd0, 1'b1, 3'd0);
        idle(4);

        // Overflow: words 41..48 are dropped with errors.
        for (int i = 1; i <= 48; i++) step(1'b1, 32'(i * 7), 1'b0, 3'd0);
        step(1'b0, 32'd0, 1'b1, 3'd4);
        idle(8);

        // Collision in idle, then write while busy.
        load_rand(5);
        step(1'b1, $urandom, 1'b1, 3'd4);
        step(1'b0, 32'd0, 1'b1, 3'd0);
        step(1'b1, $urandom, 1'b0, 3'd0);
        step(1'b0, 32'd0, 1'b1, 3'd0);
        idle(4);

        // Drive the error counter past saturation.
        for (int i = 0; i < 300; i++) step(1'b1, $urandom, 1'b1, 3'($urandom));
        idle(2);

        // Asynchronous reset in the third frame cycle of a four-operand launch.
        load_rand(32);
        step(1'b0, 32'd0, 1'b1, 3'd5);
        idle(2);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midsend_reset");
        sq.delete();
        eq.delete();
        busy_lo = 1;
        busy_hi = 0;
        clear_model();
        errc = 0;
        @(negedge clk);
        chk_all_zero("held_reset");
        rst_n = 1'b1;
        load_rand(32);
        step(1'b0, 32'd0, 1'b1, 3'd5);
        idle(8);

        // Randomised traffic: near-miss operand counts, stray words, collisions.
        for (int it = 0; it < 40; it++) begin
            m = int'($urandom_range(7));
            n = req_ops(3'(m));
            nops = (n < 0) ? int'($urandom_range(2)) : n + int'($urandom_range(2)) - 1;
            if (nops < 0) nops = 0;
            nw = nops * 8;
            if ($urandom_range(3) == 0) nw += int'($urandom_range(7, 1));
            load_rand(nw);
            idle(int'($urandom_range(2)));
            step(($urandom_range(7) == 0), $urandom, 1'b1, 3'(m));
            for (int j = 0; j < 6; j++)
                step(($urandom_range(2) == 0), $urandom, ($urandom_range(1) == 0), 3'($urandom));
            idle(int'($urandom_range(8)));
        end

        idle(12);
        chk("frames_drained", 256'(sq.size()), '0);
        chk("errors_drained", 256'(eq.size()), '0);
        chk("err_cnt_final", 256'(err_cnt), 256'(errc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
